// File: rtl/test_status_monitor.sv
// test_status_monitor: end-of-test monitor watching tohost/console stores, counting cycles and
// retirements, enforcing a watchdog and buffering console bytes for the bench.
module test_status_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_1004,
  parameter int unsigned TIMEOUT_CYCLES = 190,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        retire_valid,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        con_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {RUN, DONE} state_t;
  state_t      state_q;
  logic        done_q, pass_q, timeout_q, con_valid_q, con_overflow_q;
  logic [30:0] fail_code_q;
  logic [31:0] cc_q, ir_q;
  logic [7:0]  con_data_q, con_data_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic        term, wdog, push, pop, full, accept, con_valid_d;
  logic [7:0]  head;
  always_comb begin
    term        = state_q == RUN && mem_we && mem_addr == TOHOST_ADDR && mem_wdata[0];
    wdog        = state_q == RUN && !term && cc_q == 32'(TIMEOUT_CYCLES - 1);
    push        = mem_we && mem_addr == CONSOLE_ADDR;
    pop         = con_valid_q && con_ready;
    full        = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
    accept      = push && (!full || pop);
    wptr_d      = wptr_q + {{AW{1'b0}}, accept};
    rptr_d      = rptr_q + {{AW{1'b0}}, pop};
    con_valid_d = wptr_d != rptr_d;
    // a byte pushed into an otherwise-empty FIFO becomes the head without going through mem_q
    head        = (accept && wptr_q[AW-1:0] == rptr_d[AW-1:0]) ? mem_wdata[7:0] : mem_q[rptr_d[AW-1:0]];
    con_data_d  = con_valid_d ? head : con_data_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= RUN;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      cc_q        <= '0;
      ir_q        <= '0;
    end else if (state_q == RUN) begin
      cc_q <= (&cc_q) ? cc_q : cc_q + 32'd1;
      if (retire_valid && !(&ir_q)) ir_q <= ir_q + 32'd1;
      if (term) begin
        state_q     <= DONE;
        done_q      <= 1'b1;
        fail_code_q <= mem_wdata[31:1];
        pass_q      <= mem_wdata[31:1] == '0;
      end else if (wdog) begin
        state_q     <= DONE;
        done_q      <= 1'b1;
        timeout_q   <= 1'b1;
        pass_q      <= 1'b0;
        fail_code_q <= '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      con_valid_q    <= 1'b0;
      con_data_q     <= '0;
      con_overflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
      if (push && !accept) con_overflow_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q[AW-1:0]] <= mem_wdata[7:0];
  end
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign fail_code     = fail_code_q;
  assign cycle_count   = cc_q;
  assign instret_count = ir_q;
  assign con_valid     = con_valid_q;
  assign con_data      = con_data_q;
  assign con_overflow  = con_overflow_q;
endmodule
